ask_secded_link: RTL and testbench
==================================

ASK_SECDED_LINK -- requirements
Module: ask_secded_link

Interface
REQ-001 Parameter SPB, default 128: samples per transmitted bit; legal range 2..1024.
REQ-002 Parameter THRESH, default 128: 8-bit sample-count threshold; a sample counts when its value > THRESH.
REQ-003 Parameter VOTE, default SPB/4: a bit is received as 1 when its count > VOTE; VOTE < SPB.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  source offers in_data.
REQ-007 in_ready  output  1  block accepts a word; high only in IDLE.
REQ-008 in_data  input  4  nibble to transmit.
REQ-009 freq  input  16  phase increment per sample; sampled every cycle.
REQ-010 noise_mask  input  8  per-bit flip mask on the codeword; present only with the macro in REQ-034.
REQ-011 ask_out  output  8  registered modulated sample, for observation.
REQ-012 out_valid  output  1  decoded result valid.
REQ-013 out_ready  input  1  sink accepts the result.
REQ-014 out_data  output  4  decoded nibble.
REQ-015 err_corr / err_double / err_parity  output  1 each  SECDED status, valid with out_valid.

Function
REQ-016 FSM states: IDLE, TX, DECODE, DONE.
- IDLE->TX on in_valid&&in_ready.
- TX->DECODE after 8*SPB samples.
- DECODE->DONE after 1 cycle.
- DONE->IDLE on out_valid&&out_ready.
REQ-017 On accept, latch codeword cw[7:0] = {P, d3,d2,d1,p4,d0,p2,p1}.
- p1=d0^d1^d3; p2=d0^d2^d3; p4=d1^d2^d3.
- P = XOR of the other 7 bits.
- cw is XORed with noise_mask when that port is present.
REQ-018 On accept, clear the 16-bit phase accumulator, bit index, and sample counter; in TX, add freq to the phase accumulator every cycle, wrapping modulo 2^16.
REQ-019 Sample s = cw[bit_idx] ? LUT[phase[15:12]] : 0, where LUT (16 entries) = 128,176,218,245,255,245,218,176,128,80,38,11,0,11,38,80.
REQ-020 Each TX cycle: ask_out <= s; vote counter increments when s > THRESH.
REQ-021 At the end of the SPB-th sample of a bit:
- rx[bit_idx] <= (count > VOTE).
- Clear the count.
- Increment bit_idx; bits are sent LSB first (cw[0]..cw[7]).
REQ-022 DECODE: syndrome S = {rx[3]^rx[4]^rx[5]^rx[6], rx[1]^rx[2]^rx[5]^rx[6], rx[0]^rx[2]^rx[4]^rx[6]}; overall O = ^rx[7:0].
REQ-023 SECDED status:
- S!=0, O=1: flip rx bit S-1; err_corr=1.
- S!=0, O=0: no correction; err_double=1.
- S=0, O=1: err_parity=1.
- Otherwise: all status flags 0.
REQ-024 out_data = {c[6],c[5],c[4],c[2]} of the corrected 7-bit word c; registered, and with the status flags, set on the DECODE->DONE edge.
REQ-025 Latency: out_valid rises on edge 8*SPB+1 after the accepting edge.
REQ-026 DONE: out_valid=1; out_data and flags held stable until out_ready.
REQ-027 in_valid outside IDLE is ignored.
REQ-028 freq changes mid-frame take effect on the next sample.
REQ-029 freq=0: every sample is 128, so no sample is counted and every bit is received as 0.
REQ-030 ask_out = 0 outside TX.

Reset
REQ-031 reset forces state IDLE at any time, including mid-frame; the frame is discarded.
REQ-032 Reset values:
- in_ready=1.
- out_valid=0, out_data=0, all error flags=0.
- ask_out=0.
- Phase accumulator, counters, cw, and rx all 0.
REQ-033 The first accept is possible on the first rising edge after reset deasserts.

Configuration
REQ-034 Macro ASK_SECDED_LINK_NOISE_EN:
- Defined: noise_mask port exists and is applied per REQ-017.
- Undefined: port absent; cw is transmitted unmodified.

Verification
REQ-035 Bench configuration: SPB=128, THRESH=128, VOTE=32, freq=16'h1000, noise_mask=0.
REQ-036 in_data=4'hB -> out_data=4'hB, all flags 0, out_valid on edge 1025 after accept.
REQ-037 in_data=4'h5, noise_mask=8'h04 -> out_data=4'h5, err_corr=1.
REQ-038 in_data=4'h5, noise_mask=8'h03 -> err_double=1, err_corr=0, err_parity=0.
REQ-039 in_data=4'hA, noise_mask=8'h80 -> out_data=4'hA, err_parity=1; separately, freq=0 with in_data=4'hF -> out_data=0, all flags 0.
REQ-040 Backpressure and reset:
- Hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0.
- Assert reset at sample 300 of TX -> all outputs at reset values; in_ready=1 after release.

Source files
------------

// File: rtl/ask_secded_link.sv
// SECDED(8,4) nibble link: encodes a nibble, ASK-modulates it one bit per SPB samples, majority-votes
// it back and corrects it. Result valid 8*SPB+1 edges after accept.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Optional ASK_SECDED_LINK_NOISE_EN adds a noise_mask port that flips codeword bits before transmission.
module ask_secded_link #(
  parameter int SPB    = 128,
  parameter int THRESH = 128,
  parameter int VOTE   = SPB / 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic [15:0] freq,
`ifdef ASK_SECDED_LINK_NOISE_EN
  input  logic [7:0]  noise_mask,
`endif
  output logic [7:0]  ask_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        err_corr,
  output logic        err_double,
  output logic        err_parity
);

  localparam int SW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int CW = $clog2(SPB + 1);

  typedef enum logic [1:0] {IDLE, TX, DECODE, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cw;
  logic [7:0]    rx;
  logic [15:0]   phase;
  logic [2:0]    bit_idx;
  logic [SW-1:0] samp_cnt;
  logic [CW-1:0] vote_cnt;

  logic [7:0]    cw_enc;
  logic [7:0]    cw_tx;
  logic [7:0]    lut_val;
  logic [7:0]    samp;
  logic          last_samp;
  logic          vote_inc;
  logic [CW-1:0] vote_nxt;
  logic          vote_bit;
  logic [2:0]    syn;
  logic          ovr;
  logic [6:0]    flip;
  logic [6:0]    corr_word;
  logic [3:0]    dec_data;
  logic          dec_corr;
  logic          dec_double;
  logic          dec_parity;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Hamming(7,4) plus overall parity; noise is applied to the word as latched
  always_comb begin
    cw_enc    = 8'd0;
    cw_enc[0] = in_data[0] ^ in_data[1] ^ in_data[3];
    cw_enc[1] = in_data[0] ^ in_data[2] ^ in_data[3];
    cw_enc[2] = in_data[0];
    cw_enc[3] = in_data[1] ^ in_data[2] ^ in_data[3];
    cw_enc[4] = in_data[1];
    cw_enc[5] = in_data[2];
    cw_enc[6] = in_data[3];
    cw_enc[7] = ^cw_enc[6:0];
`ifdef ASK_SECDED_LINK_NOISE_EN
    cw_tx     = cw_enc ^ noise_mask;
`else
    cw_tx     = cw_enc;
`endif
  end

  // One-period sine LUT indexed by the top phase nibble, gated by the current code bit
  always_comb begin
    lut_val = 8'd128;
    case (phase[15:12])
      4'd0:  lut_val = 8'd128;
      4'd1:  lut_val = 8'd176;
      4'd2:  lut_val = 8'd218;
      4'd3:  lut_val = 8'd245;
      4'd4:  lut_val = 8'd255;
      4'd5:  lut_val = 8'd245;
      4'd6:  lut_val = 8'd218;
      4'd7:  lut_val = 8'd176;
      4'd8:  lut_val = 8'd128;
      4'd9:  lut_val = 8'd80;
      4'd10: lut_val = 8'd38;
      4'd11: lut_val = 8'd11;
      4'd12: lut_val = 8'd0;
      4'd13: lut_val = 8'd11;
      4'd14: lut_val = 8'd38;
      4'd15: lut_val = 8'd80;
      default: lut_val = 8'd128;
    endcase
    samp      = cw[bit_idx] ? lut_val : 8'd0;
    last_samp = (samp_cnt == SW'(SPB - 1));
    vote_inc  = (samp > 8'(THRESH));
    vote_nxt  = vote_cnt + CW'(vote_inc);
    // The vote includes the sample taken on the closing edge of the bit
    vote_bit  = (vote_nxt > CW'(VOTE));
  end

  // Syndrome decode; a nonzero syndrome names the 1-based Hamming position in error
  always_comb begin
    syn[0]     = rx[0] ^ rx[2] ^ rx[4] ^ rx[6];
    syn[1]     = rx[1] ^ rx[2] ^ rx[5] ^ rx[6];
    syn[2]     = rx[3] ^ rx[4] ^ rx[5] ^ rx[6];
    ovr        = ^rx;
    flip       = 7'd0;
    dec_corr   = 1'b0;
    dec_double = 1'b0;
    dec_parity = 1'b0;
    if (syn != 3'd0 && ovr) begin
      flip     = 7'd1 << (syn - 3'd1);
      dec_corr = 1'b1;
    end else if (syn != 3'd0) begin
      dec_double = 1'b1;
    end else if (ovr) begin
      dec_parity = 1'b1;
    end
    corr_word = rx[6:0] ^ flip;
    dec_data  = {corr_word[6], corr_word[5], corr_word[4], corr_word[2]};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                      state_nxt = TX;
      TX:      if (last_samp && bit_idx == 3'd7)  state_nxt = DECODE;
      DECODE:                                     state_nxt = DONE;
      DONE:    if (out_ready)                     state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, modulate and vote in TX, register the decode result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw         <= 8'd0;
      rx         <= 8'd0;
      phase      <= 16'd0;
      bit_idx    <= 3'd0;
      samp_cnt   <= '0;
      vote_cnt   <= '0;
      ask_out    <= 8'd0;
      out_data   <= 4'd0;
      err_corr   <= 1'b0;
      err_double <= 1'b0;
      err_parity <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ask_out <= 8'd0;
          if (in_valid) begin
            cw       <= cw_tx;
            rx       <= 8'd0;
            phase    <= 16'd0;
            bit_idx  <= 3'd0;
            samp_cnt <= '0;
            vote_cnt <= '0;
          end
        end
        TX: begin
          ask_out <= samp;
          phase   <= phase + freq;
          if (last_samp) begin
            rx[bit_idx] <= vote_bit;
            vote_cnt    <= '0;
            samp_cnt    <= '0;
            bit_idx     <= bit_idx + 3'd1;
          end else begin
            vote_cnt <= vote_nxt;
            samp_cnt <= samp_cnt + SW'(1);
          end
        end
        DECODE: begin
          ask_out    <= 8'd0;
          out_data   <= dec_data;
          err_corr   <= dec_corr;
          err_double <= dec_double;
          err_parity <= dec_parity;
        end
        default: ask_out <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ask_secded_link.sv
// Randomized bench for ask_secded_link against a frame-level reference model.
// Model works from Hamming positions, closed-form phase and per-bit sample votes.
// Build with ASK_SECDED_LINK_NOISE_EN defined to exercise the noise_mask cases as well.
module tb_ask_secded_link;
  localparam int SPB    = 128;
  localparam int THRESH = 128;
  localparam int VOTE   = 32;
  localparam int FRAME  = 8 * SPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'd0;
  logic [15:0] freq = 16'h1000;
`ifdef ASK_SECDED_LINK_NOISE_EN
  logic [7:0]  noise_mask = 8'd0;
`endif
  logic [7:0]  ask_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        err_corr, err_double, err_parity;

  int checks = 0;
  int errors = 0;
  int lut [16] = '{128, 176, 218, 245, 255, 245, 218, 176, 128, 80, 38, 11, 0, 11, 38, 80};

  ask_secded_link #(.SPB(SPB), .THRESH(THRESH), .VOTE(VOTE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .freq(freq),
`ifdef ASK_SECDED_LINK_NOISE_EN
    .noise_mask(noise_mask),
`endif
    .ask_out(ask_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_corr(err_corr), .err_double(err_double),
    .err_parity(err_parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Codeword as sent: Hamming position j (1..7) lives in bit j-1, overall parity in bit 7
  function automatic logic [7:0] encode(input logic [3:0] nib, input logic [7:0] mask);
    logic [7:1] pos;
    pos    = '0;
    pos[3] = nib[0];
    pos[5] = nib[1];
    pos[6] = nib[2];
    pos[7] = nib[3];
    for (int k = 0; k < 3; k++)
      for (int j = 3; j <= 7; j++)
        if (j != 4 && ((j >> k) & 1) == 1) pos[1 << k] = pos[1 << k] ^ pos[j];
    return {^pos, pos} ^ mask;
  endfunction

  // Phase seen by sample n: freq fa for the cycles before sw, fb from there on
  function automatic int phase_at(input int fa, input int fb, input int sw, input int n);
    if (n <= sw) return (n * fa) % 65536;
    return (sw * fa + (n - sw) * fb) % 65536;
  endfunction

  function automatic int samp_at(input logic [7:0] cw, input int fa, input int fb,
                                 input int sw, input int n);
    if (cw[n / SPB] == 1'b0) return 0;
    return lut[phase_at(fa, fb, sw, n) / 4096];
  endfunction

  // Returns {err_parity, err_double, err_corr, data}
  function automatic logic [6:0] model_frame(input logic [3:0] nib, input logic [7:0] mask,
                                             input int fa, input int fb, input int sw);
    logic [7:0] cw, rx;
    int cnt, syn;
    logic ov, c, d, p;
    cw = encode(nib, mask);
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int s = 0; s < SPB; s++)
        if (samp_at(cw, fa, fb, sw, b * SPB + s) > THRESH) cnt++;
      rx[b] = (cnt > VOTE);
    end
    syn = 0;
    for (int j = 1; j <= 7; j++) if (rx[j-1]) syn = syn ^ j;
    ov = ($countones(rx) % 2) == 1;
    c = (syn != 0) && ov;
    d = (syn != 0) && !ov;
    p = (syn == 0) && ov;
    if (c) rx[syn-1] = ~rx[syn-1];
    return {p, d, c, rx[6], rx[5], rx[4], rx[2]};
  endfunction

  // Starts #1 after an edge in IDLE; accepts, runs the frame, checks result, then releases it
  task automatic run_frame(input logic [3:0] nib, input logic [7:0] mask, input logic [15:0] fa,
                           input logic [15:0] fb, input int sw, input int hold);
    logic [6:0] exp;
    logic [7:0] m;
    logic [7:0] cw;
    logic [6:0] snap;
    logic stable;
    int lat;
`ifdef ASK_SECDED_LINK_NOISE_EN
    m = mask;
    noise_mask = mask;
`else
    m = 8'd0;
`endif
    exp = model_frame(nib, m, int'(fa), int'(fb), sw);
    cw  = encode(nib, m);
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = nib;
    freq     = fa;
    @(posedge clk); #1;
    lat = 0;
    for (int e = 1; e <= FRAME + 20; e++) begin
      freq     = ((e - 1) < sw) ? fa : fb;
      in_valid = (e < FRAME - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 4'($urandom);
      @(posedge clk); #1;
      if (e == SPB) chk("in_ready_tx", in_ready, 0);
      if (e == 3 * SPB + 7) chk("ask_sample", ask_out, samp_at(cw, int'(fa), int'(fb), sw, e - 1));
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    in_valid = 1'b0;
    chk("latency", lat, FRAME + 1);
    chk("out_data", out_data, exp[3:0]);
    chk("err_corr", err_corr, exp[4]);
    chk("err_double", err_double, exp[5]);
    chk("err_parity", err_parity, exp[6]);
    snap   = {out_data, err_corr, err_double, err_parity};
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if ({out_data, err_corr, err_double, err_parity} !== snap || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || ask_out !== 8'd0) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    chk("ask_idle", ask_out, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_flags"}, {err_corr, err_double, err_parity}, 0);
    chk({tag, "_ask_out"}, ask_out, 0);
  endtask

  initial begin
    logic [7:0] mk;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Nominal frame, first accept on the first edge after reset release, long backpressure
    run_frame(4'hB, 8'h00, 16'h1000, 16'h1000, 0, 20);
`ifdef ASK_SECDED_LINK_NOISE_EN
    run_frame(4'h5, 8'h04, 16'h1000, 16'h1000, 0, 2);
    run_frame(4'h5, 8'h03, 16'h1000, 16'h1000, 0, 1);
    run_frame(4'hA, 8'h80, 16'h1000, 16'h1000, 0, 0);
`endif
    run_frame(4'hF, 8'h00, 16'h0000, 16'h0000, 0, 0);
    // freq drops to 0 mid-frame: phase freezes from the next sample on
    run_frame(4'h6, 8'h00, 16'h1000, 16'h0000, 300, 1);

    // Reset while sample 300 of TX has just been taken
    in_valid = 1'b1;
    in_data  = 4'h9;
    freq     = 16'h1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("pre_reset_tx", in_ready, 0);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_ready", in_ready, 1);
    run_frame(4'h3, 8'h00, 16'h1000, 16'h1000, 0, 0);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0:       mk = 8'd0;
        1:       mk = 8'd1 << $urandom_range(0, 7);
        default: mk = (8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7));
      endcase
      run_frame(4'($urandom), mk,
                ($urandom_range(0, 1) == 1) ? 16'h1000 : 16'($urandom),
                16'($urandom), $urandom_range(0, FRAME), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
